// File: rtl/accum_alu_pkg.sv
// Shared types for the accumulating ALU pipeline: operating modes, the
// combinational result bundle and small helpers used by the core and the top.
package accum_alu_pkg;

  // Operating modes as presented on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Widest operand the result bundle can carry. Each instance uses only the
  // low WIDTH bits of value; the bits above are always driven to zero.
  localparam int ALU_MAX_W = 64;

  // Result of one ALU operation: value plus the three status flags.
  typedef struct packed {
    logic [ALU_MAX_W-1:0] value;
    logic                 carry;
    logic                 ovf;
    logic                 sat;
  } alu_res_t;

  // Two's-complement overflow from the sign bits of both operands and the
  // result: operands agree in sign and the result disagrees with them.
  function automatic logic signed_ovf(input logic sign_x, input logic sign_y,
                                      input logic sign_r);
    return (sign_x == sign_y) && (sign_r != sign_x);
  endfunction

  // Only ACC and LOAD write the accumulator.
  function automatic logic mode_writes_acc(input mode_e m);
    return (m == MODE_ACC) || (m == MODE_LOAD);
  endfunction

endpackage

// File: rtl/accum_alu_core.sv
// Combinational datapath: computes the result value and the carry, overflow
// and saturation flags for one operation. Holds no state.
module accum_alu_core
  import accum_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             ovf,
  output logic             sat
);

  mode_e            op;
  logic [WIDTH:0]   ext;
  alu_res_t         res;
  logic             unused_res_bits;

  assign op = mode_e'(mode);

  // Raw arithmetic at WIDTH+1 bits so bit WIDTH is the carry (or the borrow
  // for subtraction of zero-extended operands), then optional clamping.
  always_comb begin
    ext = '0;
    res = '0;
    case (op)
      MODE_ADD: begin
        ext       = {1'b0, a} + {1'b0, b};
        res.carry = ext[WIDTH];
        res.ovf   = signed_ovf(a[WIDTH-1], b[WIDTH-1], ext[WIDTH-1]);
      end
      MODE_SUB: begin
        ext       = {1'b0, a} - {1'b0, b};
        res.carry = ext[WIDTH];
        res.ovf   = signed_ovf(a[WIDTH-1], ~b[WIDTH-1], ext[WIDTH-1]);
      end
      MODE_ACC: begin
        ext       = {1'b0, acc} + {1'b0, a};
        res.carry = ext[WIDTH];
        res.ovf   = signed_ovf(acc[WIDTH-1], a[WIDTH-1], ext[WIDTH-1]);
      end
      default: begin
        ext = {1'b0, a};
      end
    endcase
    res.value = ALU_MAX_W'(ext[WIDTH-1:0]);
    if (SAT_EN && res.carry) begin
      res.sat = 1'b1;
      if (op == MODE_SUB) begin
        res.value = '0;
      end else begin
        res.value = ALU_MAX_W'({WIDTH{1'b1}});
      end
    end
  end

  assign value = res.value[WIDTH-1:0];
  assign carry = res.carry;
  assign ovf   = res.ovf;
  assign sat   = res.sat;

  // Bits of the bundle above WIDTH are constant zero; fold them into one
  // signal so the whole bundle is consumed.
  assign unused_res_bits = ^res.value;

endmodule

// File: rtl/accum_alu_pipe.sv
// Registered accumulating ALU with a valid/ready handshake and a one-entry
// output register. The arithmetic lives in accum_alu_core; this level holds
// the handshake, the result/accumulator registers and the operation counter.
module accum_alu_pipe
  import accum_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             sat,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             accept;
  logic [WIDTH-1:0] core_value;
  logic             core_carry;
  logic             core_ovf;
  logic             core_sat;

  accum_alu_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .a     (a),
    .b     (b),
    .acc   (acc),
    .mode  (mode),
    .value (core_value),
    .carry (core_carry),
    .ovf   (core_ovf),
    .sat   (core_sat)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drop valid once consumed, otherwise hold
  // (covers the stall case where nothing is sampled).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      sat       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= core_value;
      carry     <= core_carry;
      ovf       <= core_ovf;
      sat       <= core_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator takes the final (possibly clamped) value of accepted ACC and
  // LOAD operations only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && mode_writes_acc(mode_e'(mode))) begin
      acc <= core_value;
    end
  end

  // Count accepted operations, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (accept) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_accum_alu_pipe.sv
// Bench for accum_alu_pipe: two instances (wrap-around and saturating) share
// one stimulus stream and are checked every cycle against an arithmetic
// model, plus hand-computed expectations at key points.
module tb_accum_alu_pipe;
  import accum_alu_pkg::*;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;

  logic       in_ready_o  [2];
  logic       out_valid_o [2];
  logic [7:0] result_o    [2];
  logic       carry_o     [2];
  logic       ovf_o       [2];
  logic       sat_o       [2];
  logic [7:0] acc_o       [2];
  logic [7:0] cnt_o       [2];

  int  n_checks = 0;
  int  n_fails  = 0;
  bit  checking = 1'b0;

  int  m_valid [2];
  int  m_result[2];
  int  m_carry [2];
  int  m_ovf   [2];
  int  m_sat   [2];
  int  m_acc   [2];
  int  m_count [2];

  always #5 clk = ~clk;

  accum_alu_pipe #(.WIDTH(8), .SAT_EN(1'b0), .CNT_W(8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .result(result_o[0]), .carry(carry_o[0]), .ovf(ovf_o[0]), .sat(sat_o[0]),
    .acc(acc_o[0]), .op_count(cnt_o[0])
  );

  accum_alu_pipe #(.WIDTH(8), .SAT_EN(1'b1), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .result(result_o[1]), .carry(carry_o[1]), .ovf(ovf_o[1]), .sat(sat_o[1]),
    .acc(acc_o[1]), .op_count(cnt_o[1])
  );

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s[%0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int toSigned(input int u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  // Plain integer arithmetic: range tests decide carry/overflow/clamping.
  task automatic modelOp(input bit sat_en, input int md, input int ua,
                         input int ub, input int uacc, output int val,
                         output int c, output int o, output int s);
    int raw;
    int sraw;
    val = 0; c = 0; o = 0; s = 0;
    case (md)
      0: begin raw = ua + ub;   sraw = toSigned(ua) + toSigned(ub);   c = int'(raw >= MOD); end
      1: begin raw = ua - ub;   sraw = toSigned(ua) - toSigned(ub);   c = int'(ua < ub);    end
      2: begin raw = uacc + ua; sraw = toSigned(uacc) + toSigned(ua); c = int'(raw >= MOD); end
      default: begin raw = ua; sraw = 0; end
    endcase
    val = (raw + MOD) % MOD;
    o   = int'(sraw > MOD / 2 - 1 || sraw < -(MOD / 2));
    if (sat_en && c == 1) begin
      s   = 1;
      val = (md == 1) ? 0 : MOD - 1;
    end
  endtask

  // Reference model advances on each rising edge from the inputs in force.
  always @(posedge clk) begin
    int v, c, o, s;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_valid[k] = 0; m_result[k] = 0; m_carry[k] = 0; m_ovf[k] = 0;
        m_sat[k] = 0; m_acc[k] = 0; m_count[k] = 0;
      end else if (in_valid && (m_valid[k] == 0 || out_ready)) begin
        modelOp(k == 1, int'(mode), int'(a), int'(b), m_acc[k], v, c, o, s);
        m_valid[k] = 1; m_result[k] = v; m_carry[k] = c; m_ovf[k] = o; m_sat[k] = s;
        if (mode == MODE_ACC || mode == MODE_LOAD) m_acc[k] = v;
        m_count[k] = (m_count[k] + 1) % MOD;
      end else if (out_ready) begin
        m_valid[k] = 0;
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("m_out_valid", k, 32'(out_valid_o[k]), 32'(m_valid[k]));
        checkOutput("m_in_ready", k, 32'(in_ready_o[k]),
                    32'(m_valid[k] == 0 || out_ready));
        checkOutput("m_result", k, 32'(result_o[k]), 32'(m_result[k]));
        checkOutput("m_carry", k, 32'(carry_o[k]), 32'(m_carry[k]));
        checkOutput("m_ovf", k, 32'(ovf_o[k]), 32'(m_ovf[k]));
        checkOutput("m_sat", k, 32'(sat_o[k]), 32'(m_sat[k]));
        checkOutput("m_acc", k, 32'(acc_o[k]), 32'(m_acc[k]));
        checkOutput("m_op_count", k, 32'(cnt_o[k]), 32'(m_count[k]));
      end
    end
  end

  // Drive one cycle of inputs, then return just after the edge that used them.
  task automatic applyStimulus(input logic v, input mode_e md, input logic [7:0] aa,
                               input logic [7:0] bb, input logic ordy, input logic rn);
    in_valid  = v;
    mode      = md;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    rst_n     = rn;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 8'd9; b = 8'd9; mode = MODE_ADD;
    repeat (2) @(posedge clk);
    #2;
    checking = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_out_valid", k, 32'(out_valid_o[k]), 32'd0);
      checkOutput("rst_result", k, 32'(result_o[k]), 32'd0);
      checkOutput("rst_acc", k, 32'(acc_o[k]), 32'd0);
      checkOutput("rst_op_count", k, 32'(cnt_o[k]), 32'd0);
      checkOutput("rst_in_ready", k, 32'(in_ready_o[k]), 32'd1);
    end

    applyStimulus(1'b1, MODE_ADD, 8'd200, 8'd100, 1'b1, 1'b1);
    checkOutput("add_result", 0, 32'(result_o[0]), 32'd44);
    checkOutput("add_carry", 0, 32'(carry_o[0]), 32'd1);
    checkOutput("add_ovf", 0, 32'(ovf_o[0]), 32'd0);
    checkOutput("add_valid", 0, 32'(out_valid_o[0]), 32'd1);
    checkOutput("add_count", 0, 32'(cnt_o[0]), 32'd1);
    checkOutput("add_sat_result", 1, 32'(result_o[1]), 32'd255);

    applyStimulus(1'b1, MODE_SUB, 8'h80, 8'h01, 1'b1, 1'b1);
    checkOutput("sub_result", 1, 32'(result_o[1]), 32'h7F);
    checkOutput("sub_carry", 1, 32'(carry_o[1]), 32'd0);
    checkOutput("sub_ovf", 1, 32'(ovf_o[1]), 32'd1);
    checkOutput("sub_sat", 1, 32'(sat_o[1]), 32'd0);

    applyStimulus(1'b1, MODE_SUB, 8'd5, 8'd9, 1'b1, 1'b1);
    checkOutput("borrow_result", 1, 32'(result_o[1]), 32'd0);
    checkOutput("borrow_carry", 1, 32'(carry_o[1]), 32'd1);
    checkOutput("borrow_sat", 1, 32'(sat_o[1]), 32'd1);
    checkOutput("borrow_wrap_result", 0, 32'(result_o[0]), 32'd252);

    applyStimulus(1'b1, MODE_LOAD, 8'd250, 8'd3, 1'b1, 1'b1);
    checkOutput("load_acc", 1, 32'(acc_o[1]), 32'd250);
    checkOutput("load_acc", 0, 32'(acc_o[0]), 32'd250);

    applyStimulus(1'b1, MODE_ACC, 8'd10, 8'd77, 1'b1, 1'b1);
    checkOutput("acc_sat_result", 1, 32'(result_o[1]), 32'd255);
    checkOutput("acc_sat_acc", 1, 32'(acc_o[1]), 32'd255);
    checkOutput("acc_sat_flag", 1, 32'(sat_o[1]), 32'd1);
    checkOutput("acc_sat_carry", 1, 32'(carry_o[1]), 32'd1);
    checkOutput("acc_wrap_result", 0, 32'(result_o[0]), 32'd4);
    checkOutput("acc_wrap_acc", 0, 32'(acc_o[0]), 32'd4);

    applyStimulus(1'b0, MODE_ADD, 8'd1, 8'd1, 1'b1, 1'b1);
    checkOutput("drain_valid", 0, 32'(out_valid_o[0]), 32'd0);
    checkOutput("drain_hold", 0, 32'(result_o[0]), 32'd4);

    applyStimulus(1'b1, MODE_LOAD, 8'd77, 8'd0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, MODE_ADD, 8'd1, 8'd2, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checkOutput("stall_in_ready", k, 32'(in_ready_o[k]), 32'd0);
        checkOutput("stall_result", k, 32'(result_o[k]), 32'd77);
        checkOutput("stall_acc", k, 32'(acc_o[k]), 32'd77);
        checkOutput("stall_count", k, 32'(cnt_o[k]), 32'd6);
      end
    end
    applyStimulus(1'b1, MODE_ADD, 8'd1, 8'd2, 1'b1, 1'b1);
    checkOutput("release_valid", 0, 32'(out_valid_o[0]), 32'd1);
    checkOutput("release_result", 0, 32'(result_o[0]), 32'd3);
    checkOutput("release_count", 0, 32'(cnt_o[0]), 32'd7);

    applyStimulus(1'b1, MODE_LOAD, 8'd77, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, MODE_ADD, 8'd0, 8'd0, 1'b0, 1'b1);
    checkOutput("prerst_acc", 1, 32'(acc_o[1]), 32'd77);
    checkOutput("prerst_valid", 1, 32'(out_valid_o[1]), 32'd1);
    applyStimulus(1'b1, MODE_ADD, 8'd1, 8'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("midrst_valid", k, 32'(out_valid_o[k]), 32'd0);
      checkOutput("midrst_acc", k, 32'(acc_o[k]), 32'd0);
      checkOutput("midrst_count", k, 32'(cnt_o[k]), 32'd0);
      checkOutput("midrst_in_ready", k, 32'(in_ready_o[k]), 32'd1);
    end

    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, MODE_ADD, i[7:0], 8'd1, 1'b1, 1'b1);
      checkOutput("burst_valid", 0, 32'(out_valid_o[0]), 32'd1);
      checkOutput("burst_count", 0, 32'(cnt_o[0]), 32'((i + 1) % 256));
    end
    checkOutput("wrap_count", 1, 32'(cnt_o[1]), 32'd0);
    applyStimulus(1'b0, MODE_ADD, 8'd0, 8'd0, 1'b1, 1'b1);
    checkOutput("final_count", 0, 32'(cnt_o[0]), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
